// File: rtl/histogram_readout.sv
// ============================================================================
// Module   : histogram_readout
// Purpose  : Blanking-period sweep of the histogram accumulator into a
//            valid/ready {bin, count} stream, followed by a clear pulse.
//            Optional macro HIST_STATS_EN adds total/peak statistics.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module histogram_readout #(
    parameter int BINS   = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int SUM_W  = 26
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_valid,
    input  logic              enable,
    output logic              hist_rd_en,
    output logic [ADDR_W-1:0] hist_rd_addr,
    input  logic [DATA_W-1:0] hist_rd_data,
    output logic              hist_clear,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_bin,
    output logic [DATA_W-1:0] m_count,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [SUM_W-1:0]  stat_total,
    output logic [ADDR_W-1:0] stat_peak_bin,
    output logic [DATA_W-1:0] stat_peak_val
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    state_t              state_q;
    logic                fv_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W-1:0]   addr_inflight_q;
    logic                inflight_q;
    logic                busy_q;
    logic                clear_q;
    logic                done_q;
    logic                overrun_q;

    logic [1:0][ADDR_W-1:0] fifo_bin_q;
    logic [1:0][DATA_W-1:0] fifo_cnt_q;
    logic                   wr_q;
    logic                   rd_q;
    logic [1:0]             occ_q;

    logic frame_end;
    logic start;
    logic abort;
    logic push;
    logic pop;
    logic room;
    logic issue;
    logic drain_done;

    assign frame_end  = fv_q & ~frame_valid;
    assign start      = (state_q == S_IDLE) & frame_end & enable;
    assign abort      = ((state_q == S_SWEEP) | (state_q == S_DRAIN)) & frame_valid;
    assign push       = inflight_q & ~abort;
    assign pop        = m_valid & m_ready;
    // A beat leaving this cycle frees a slot, which keeps one beat per cycle.
    assign room       = (({1'b0, occ_q} + {2'b00, inflight_q}) - {2'b00, pop}) < 3'd2;
    assign issue      = start | ((state_q == S_SWEEP) & ~frame_valid & room);
    assign drain_done = (state_q == S_DRAIN) & ~frame_valid & ~inflight_q & (occ_q == 2'd0);

    assign hist_rd_en   = issue;
    assign hist_rd_addr = ptr_q;
    assign hist_clear   = clear_q;
    assign done         = done_q;
    assign overrun      = overrun_q;
    assign busy         = busy_q;

    assign m_valid = (occ_q != 2'd0);
    assign m_bin   = fifo_bin_q[rd_q];
    assign m_count = fifo_cnt_q[rd_q];
    assign m_last  = m_valid & (m_bin == ADDR_W'(BINS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            fv_q            <= 1'b0;
            ptr_q           <= '0;
            addr_inflight_q <= '0;
            inflight_q      <= 1'b0;
            busy_q          <= 1'b0;
            clear_q         <= 1'b0;
            done_q          <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            fv_q            <= frame_valid;
            clear_q         <= 1'b0;
            done_q          <= 1'b0;
            overrun_q       <= 1'b0;
            inflight_q      <= issue;
            addr_inflight_q <= ptr_q;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_SWEEP;
                        busy_q  <= 1'b1;
                        ptr_q   <= ADDR_W'(1);
                    end
                end
                S_SWEEP: begin
                    if (abort) begin
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                        overrun_q  <= 1'b1;
                        ptr_q      <= '0;
                        inflight_q <= 1'b0;
                    end else if (issue) begin
                        if (ptr_q == ADDR_W'(BINS - 1)) begin
                            state_q <= S_DRAIN;
                            ptr_q   <= '0;
                        end else begin
                            ptr_q <= ptr_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                        overrun_q  <= 1'b1;
                        inflight_q <= 1'b0;
                    end else if (drain_done) begin
                        state_q <= S_CLEAR;
                        clear_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry output FIFO; an abort discards both stored beats and the in-flight read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_bin_q <= '0;
            fifo_cnt_q <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            occ_q      <= 2'd0;
        end else if (abort) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            occ_q <= 2'd0;
        end else begin
            if (push) begin
                fifo_bin_q[wr_q] <= addr_inflight_q;
                fifo_cnt_q[wr_q] <= hist_rd_data;
                wr_q             <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            occ_q <= (occ_q + {1'b0, push}) - {1'b0, pop};
        end
    end

`ifdef HIST_STATS_EN
    logic [SUM_W-1:0]  sum_q;
    logic [ADDR_W-1:0] peak_bin_q;
    logic [DATA_W-1:0] peak_val_q;
    logic [SUM_W-1:0]  stat_total_q;
    logic [ADDR_W-1:0] stat_peak_bin_q;
    logic [DATA_W-1:0] stat_peak_val_q;

    // Strict compare so equal counts keep the lower (earlier) bin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q           <= '0;
            peak_bin_q      <= '0;
            peak_val_q      <= '0;
            stat_total_q    <= '0;
            stat_peak_bin_q <= '0;
            stat_peak_val_q <= '0;
        end else begin
            if (start) begin
                sum_q      <= '0;
                peak_bin_q <= '0;
                peak_val_q <= '0;
            end else if (push) begin
                sum_q <= sum_q + SUM_W'(hist_rd_data);
                if (hist_rd_data > peak_val_q) begin
                    peak_val_q <= hist_rd_data;
                    peak_bin_q <= addr_inflight_q;
                end
            end
            if (drain_done) begin
                stat_total_q    <= sum_q;
                stat_peak_bin_q <= peak_bin_q;
                stat_peak_val_q <= peak_val_q;
            end
        end
    end

    assign stat_total    = stat_total_q;
    assign stat_peak_bin = stat_peak_bin_q;
    assign stat_peak_val = stat_peak_val_q;
`else
    assign stat_total    = '0;
    assign stat_peak_bin = '0;
    assign stat_peak_val = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_histogram_readout.sv
// ============================================================================
// Module   : tb_histogram_readout
// Purpose  : Directed self-checking bench for histogram_readout with a
//            one-cycle-latency accumulator model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_histogram_readout;

    localparam int BINS = 1024;
    localparam int AW   = 10;
    localparam int DW   = 16;
    localparam int SW   = 26;
`ifdef HIST_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          frame_valid = 1'b1;
    logic          enable = 1'b1;
    logic          m_ready = 1'b0;
    logic          hist_rd_en;
    logic [AW-1:0] hist_rd_addr;
    logic [DW-1:0] hist_rd_data = '0;
    logic          hist_clear;
    logic          m_valid;
    logic [AW-1:0] m_bin;
    logic [DW-1:0] m_count;
    logic          m_last;
    logic          busy;
    logic          done;
    logic          overrun;
    logic [SW-1:0] stat_total;
    logic [AW-1:0] stat_peak_bin;
    logic [DW-1:0] stat_peak_val;

    logic [DW-1:0] mem [BINS];
    int total = 0;
    int bad   = 0;

    histogram_readout #(.BINS(BINS), .ADDR_W(AW), .DATA_W(DW), .SUM_W(SW)) dut (
        .clk(clk), .reset_n(reset_n), .frame_valid(frame_valid), .enable(enable),
        .hist_rd_en(hist_rd_en), .hist_rd_addr(hist_rd_addr), .hist_rd_data(hist_rd_data),
        .hist_clear(hist_clear), .m_valid(m_valid), .m_ready(m_ready), .m_bin(m_bin),
        .m_count(m_count), .m_last(m_last), .busy(busy), .done(done), .overrun(overrun),
        .stat_total(stat_total), .stat_peak_bin(stat_peak_bin), .stat_peak_val(stat_peak_val)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (hist_rd_en) hist_rd_data <= mem[hist_rd_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag, input logic [31:0] et, input logic [31:0] eb,
                             input logic [31:0] ev);
        chk({tag, "_total"}, stat_total,    STATS ? et : 32'd0);
        chk({tag, "_pbin"},  stat_peak_bin, STATS ? eb : 32'd0);
        chk({tag, "_pval"},  stat_peak_val, STATS ? ev : 32'd0);
    endtask

    // Starts at a negedge with frame_valid high and the DUT idle.
    task automatic sweep(input bit toggle, input int abort_at, input logic [31:0] et,
                         input logic [31:0] eb, input logic [31:0] ev);
        int exp_bin = 0;
        int issued  = 1;
        int acc     = 0;
        int cyc     = 0;
        bit prev_stall = 1'b0;
        bit finished   = 1'b0;
        logic [AW-1:0] pb = '0;
        logic [DW-1:0] pc = '0;
        m_ready = 1'b1;
        frame_valid = 1'b0;
        #1;
        chk("rd_en_at_frame_end", hist_rd_en, 1);
        while (!finished && cyc < 6000) begin
            @(negedge clk);
            if (abort_at >= 0 && exp_bin == abort_at) begin
                frame_valid = 1'b1;
                m_ready = 1'b0;
                @(negedge clk);
                chk("abort_overrun", overrun, 1);
                chk("abort_valid_low", m_valid, 0);
                chk("abort_busy_low", busy, 0);
                chk("abort_no_clear", hist_clear, 0);
                @(negedge clk);
                chk("overrun_one_cycle", overrun, 0);
                repeat (4) begin
                    @(negedge clk);
                    chk("abort_no_clear_later", hist_clear | done, 0);
                end
                chk_stats("abort_stats_kept", et, eb, ev);
                finished = 1'b1;
            end else begin
                if (cyc == 0) chk("first_cycle_no_valid", m_valid, 0);
                if (cyc == 1) begin
                    chk("first_beat_latency", m_valid, 1);
                    chk("first_beat_bin", m_bin, 0);
                end
                if (prev_stall) begin
                    chk("stall_valid", m_valid, 1);
                    chk("stall_bin", m_bin, pb);
                    chk("stall_count", m_count, pc);
                end
                chk("clear_with_done", hist_clear, done);
                if (hist_clear) begin
                    chk("clear_after_last", exp_bin, BINS);
                    chk_stats("done_stats", et, eb, ev);
                    finished = 1'b1;
                end
                m_ready = toggle ? (((cyc % 4 == 0) || (cyc % 4 == 3)) ^ ($urandom_range(0, 7) == 0))
                                 : 1'b1;
                #1;
                if (hist_rd_en) issued++;
                if (m_valid && m_ready) begin
                    chk("beat_bin", m_bin, exp_bin);
                    chk("beat_count", m_count, mem[exp_bin]);
                    chk("beat_last", m_last, exp_bin == BINS - 1);
                    exp_bin++;
                    acc++;
                end
                chk("outstanding_le_2", (issued - acc) <= 2, 1);
                prev_stall = m_valid && !m_ready;
                pb = m_bin;
                pc = m_count;
                cyc++;
            end
        end
        if (!finished) chk("sweep_timeout", 0, 1);
        if (abort_at < 0) begin
            @(negedge clk);
            chk("idle_after_done_busy", busy, 0);
            chk("done_one_cycle", done, 0);
        end
        frame_valid = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < BINS; i++) mem[i] = DW'(i);
        repeat (3) @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_rd_en", hist_rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clear", hist_clear | done | overrun, 0);
        chk("rst_stat_total", stat_total, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        sweep(1'b0, -1, 32'd523776, 32'd1023, 32'd1023);
        sweep(1'b1, -1, 32'd523776, 32'd1023, 32'd1023);
        sweep(1'b0, 300, 32'd523776, 32'd1023, 32'd1023);
        sweep(1'b0, -1, 32'd523776, 32'd1023, 32'd1023);

        enable = 1'b0;
        frame_valid = 1'b0;
        #1;
        chk("disabled_rd_en_now", hist_rd_en, 0);
        repeat (6) begin
            @(negedge clk);
            chk("disabled_rd_en", hist_rd_en, 0);
            chk("disabled_busy", busy, 0);
        end
        frame_valid = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b1;

        m_ready = 1'b1;
        frame_valid = 1'b0;
        repeat (50) @(negedge clk);
        chk("midsweep_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", m_valid, 0);
        chk("arst_rd_en", hist_rd_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_bin_count", {m_bin, m_count}, 0);
        chk("arst_last_clear", {m_last, hist_clear, done, overrun}, 0);
        chk("arst_stats", stat_total, 0);
        @(negedge clk);
        reset_n = 1'b1;
        frame_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_no_clear", hist_clear, 0);

        for (int i = 0; i < BINS; i++) mem[i] = '0;
        mem[5] = 16'd700;
        mem[9] = 16'd700;
        mem[20] = 16'd3;
        sweep(1'b0, -1, 32'd1403, 32'd5, 32'd700);

        for (int i = 0; i < BINS; i++) mem[i] = 16'hFFFF;
        sweep(1'b0, -1, 32'h3FFFC00, 32'd0, 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
